// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-byte data register and status flags,
// read through the 6502-style cs/we/addr/dbr register port.
module uart_rx #(
    parameter int CLK_HZ = 1843200,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       cs,
    input  logic       we,
    input  logic       addr,
    output logic [7:0] dbr
);

    localparam int BIT = CLK_HZ / BAUD;
    localparam int CW  = (BIT > 1) ? $clog2(BIT) : 1;
    localparam logic [CW-1:0] HALF = CW'(BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitcnt;
    logic [7:0]    sh;
    logic [7:0]    data;
    logic          rdy, ovr, ferr;
    logic          rxm, rxs;
    logic          rd;
    logic          busy;

    assign rd   = cs & ~we & ~addr;
    assign busy = (state != IDLE);

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxm <= 1'b1;
            rxs <= 1'b1;
        end else begin
            rxm <= rx;
            rxs <= rxm;
        end
    end

    // Frame FSM and flags; a completing byte's set wins over a same-edge read clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            sh     <= '0;
            data   <= '0;
            rdy    <= 1'b0;
            ovr    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            if (rd) begin
                rdy  <= 1'b0;
                ovr  <= 1'b0;
                ferr <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        cnt   <= HALF;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            cnt    <= FULL;
                            bitcnt <= '0;
                            state  <= DATA;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        sh     <= {rxs, sh[7:1]};
                        cnt    <= FULL;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        if (!rdy || rd) begin
                            data <= sh;
                            rdy  <= 1'b1;
                        end else begin
                            ovr <= 1'b1;
                        end
                        if (!rxs) ferr <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        dbr = 8'h00;
        if (cs && !we) dbr = addr ? {rdy, ovr, ferr, busy, 4'b0000} : data;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed bench for uart_rx at 9 clocks per bit, checked
// against a byte-level model of the data register and flags.
module tb_uart_rx;

    localparam int BITC = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       cs;
    logic       we;
    logic       addr;
    logic [7:0] dbr;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdata;
    logic       mrdy, movr, mferr;

    uart_rx #(.CLK_HZ(115200 * 9), .BAUD(115200)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .cs  (cs),
        .we  (we),
        .addr(addr),
        .dbr (dbr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] expStatus();
        return {mrdy, movr, mferr, 1'b0, 4'b0000};
    endfunction

    task automatic readReg(input logic a, output logic [7:0] v);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        v = dbr;
        @(posedge clk);
        #1;
        cs = 1'b0;
        if (!a) begin
            mrdy = 1'b0; movr = 1'b0; mferr = 1'b0;
        end
    endtask

    task automatic checkStatus(input string tag);
        logic [7:0] v;
        logic [7:0] e;
        e = expStatus();
        readReg(1'b1, v);
        checkOutput(tag, v, e);
    endtask

    task automatic checkData(input string tag);
        logic [7:0] v;
        logic [7:0] e;
        e = mdata;
        readReg(1'b0, v);
        checkOutput(tag, v, e);
    endtask

    // Drives one full frame; the model records what the byte should do once the stop bit is in.
    task automatic applyStimulus(input logic [7:0] b, input logic stopv, input bit peek);
        rx = 1'b0;
        tick(BITC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (peek && i == 4) begin
                cs = 1'b1; we = 1'b0; addr = 1'b1;
                @(negedge clk);
                checkOutput("busy", dbr & 8'h10, 8'h10);
                cs = 1'b0;
            end
            tick(BITC);
        end
        rx = stopv;
        tick(BITC);
        rx = 1'b1;
        if (!mrdy) begin
            mdata = b;
            mrdy  = 1'b1;
        end else begin
            movr = 1'b1;
        end
        if (!stopv) mferr = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        logic       sb;

        rst = 1'b1; rx = 1'b1; cs = 1'b0; we = 1'b0; addr = 1'b0;
        mdata = 8'h00; mrdy = 1'b0; movr = 1'b0; mferr = 1'b0;
        tick(3);
        checkOutput("reset_dbr", dbr, 8'h00);
        rst = 1'b0;
        tick(2);
        checkStatus("idle_status");
        checkData("idle_data");
        tick(200);
        checkStatus("idle_200");

        applyStimulus(8'h7B, 1'b1, 1'b1);
        checkStatus("rx7b_status");
        cs = 1'b0; addr = 1'b0;
        @(negedge clk);
        checkOutput("cs_low_dbr", dbr, 8'h00);
        tick(1);
        cs = 1'b1; we = 1'b1; addr = 1'b0;
        @(negedge clk);
        checkOutput("write_dbr", dbr, 8'h00);
        tick(1);
        cs = 1'b0; we = 1'b0;
        checkStatus("after_write_status");
        checkData("rx7b_data");
        checkStatus("rx7b_cleared");

        applyStimulus(8'h3E, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        tick(4);
        checkStatus("overrun_status");
        checkData("overrun_data");
        checkStatus("overrun_cleared");

        applyStimulus(8'h55, 1'b0, 1'b0);
        tick(200);
        checkStatus("ferr_status");
        checkData("ferr_data");
        checkStatus("ferr_cleared");

        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        checkStatus("glitch_status");
        applyStimulus(8'h00, 1'b1, 1'b0);
        tick(4);
        checkStatus("after_glitch_status");
        checkData("after_glitch_data");

        // Abandon a frame midway through data bit 4, releasing reset with the line idle.
        applyStimulus(8'h12, 1'b1, 1'b0);
        tick(2);
        rx = 1'b0;
        tick(BITC);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            tick(BITC);
        end
        rx = 1'b0;
        tick(4);
        rst = 1'b1;
        rx  = 1'b1;
        mdata = 8'h00; mrdy = 1'b0; movr = 1'b0; mferr = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(20);
        checkStatus("midreset_status");
        checkData("midreset_data");
        applyStimulus(8'hA5, 1'b1, 1'b0);
        tick(4);
        checkStatus("a5_status");
        checkData("a5_data");

        for (int n = 0; n < 24; n++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            applyStimulus(b, sb, ($urandom_range(0, 1) == 1));
            tick(6 + $urandom_range(0, 4));
            checkStatus("rand_status");
            if ($urandom_range(0, 2) != 0) checkData("rand_data");
        end
        checkData("final_data");
        checkStatus("final_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the 8N1 serial port. It deserializes the asynchronous `rx` line into bytes and holds the last received byte in a single data register. It also keeps the receive status flags and presents both to the 6502 bus through the same `cs`/`we`/`addr`/`dbr` register convention as the transmit UART. It sits beside the transmitter in the I/O page; writes are ignored.

## Interface
- `CLK_HZ`, default 1843200: system clock frequency in Hz.
- `BAUD`, default 115200: line rate. `BIT = CLK_HZ/BAUD` (integer division) is the clocks per bit. `BIT >= 4` is required.
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `rx` input, 1 bit: serial line. It idles high and is asynchronous to `clk`.
- `cs` input, 1 bit: chip select.
- `we` input, 1 bit: write enable. A write access (`cs & we`) has no effect.
- `addr` input, 1 bit: register select. 0 = data, 1 = status.
- `dbr` output, 8 bits: read data, combinational.

## Operation
- Input synchronizer:
  - `rx` passes through 2 flip-flops giving `rxs`.
  - Both flops reset to 1.
- Receive FSM states: IDLE, START, DATA, STOP. Bit counter is 3 bits; clock counter is wide enough to hold `BIT-1`.
- IDLE:
  - When `rxs`=0, load the clock counter with `BIT/2 - 1` and go to START.
- START:
  - When the clock counter reaches 0, sample `rxs`.
  - `rxs`=1 is a glitch: return to IDLE with no flag change.
  - `rxs`=0: reload the clock counter with `BIT-1`, clear the bit counter, go to DATA.
- DATA:
  - At each clock-counter expiry, shift `rxs` into the shift register, LSB first, and reload `BIT-1`.
  - After the 8th bit, go to STOP.
- STOP:
  - At expiry, sample the stop bit and go straight to IDLE. IDLE is entered at mid-stop-bit, so back-to-back frames are accepted.
  - If the data register is free (or being read in the same cycle), load the shift register into `data` and set `rdy`.
  - If the stop bit sampled 0, set `ferr`; the byte is still delivered.
  - If `rdy`=1 and the data register is not being read in that same cycle, discard the new byte and set `ovr`; `data` is unchanged.
- Read register map, with `dbr` = 0 whenever `cs`=0 or `we`=1:
  - `addr`=0: `data`.
  - `addr`=1: `{rdy, ovr, ferr, busy, 4'b0000}`. `busy` = FSM not in IDLE.
- Data read:
  - Any clock edge with `cs & !we & addr==0` clears `rdy`, `ovr` and `ferr`.
  - If a byte completes on that same edge, `rdy`=1 afterwards and `data` holds the new byte.
  - If that new byte also had a bad stop bit, `ferr`=1 afterwards; set takes priority over clear.
- A status read has no side effects.

## Timing
- Reset values:
  - FSM in IDLE, `data`=0x00, `rdy`=`ovr`=`ferr`=0, shift register 0, counters 0.
  - Since `cs`=0 during reset, `dbr`=0x00.
- Reset mid-frame: the partial frame is abandoned immediately (asynchronous); no flags are set.
- The falling edge of `rx` reaches `rxs` 2 edges later, and IDLE sees it on the next edge.
- Sampling points after the start is detected:
  - Start check: `BIT/2` clocks after detection.
  - Data bit k (k = 0..7): `BIT/2 + (k+1)*BIT` clocks after detection.
  - Stop bit: `BIT/2 + 9*BIT` clocks after detection.
- `rdy` is visible on `dbr` in the cycle after the stop-sample edge.
- Tolerated baud mismatch: at least ±3%.

## Test plan
All scenarios use `CLK_HZ = 115200*9`, so `BIT` = 9.
- Reset, then idle line → status read returns 0x00 and data read returns 0x00. Hold `rx`=1 for 200 clocks → status stays 0x00.
- Send frame 0x7B (start, 11011110 LSB first, stop=1) at exactly 9 clocks per bit:
  - → status bit 4 = 1 during the frame.
  - → status = 0x80 within 2 clocks after stop-bit midpoint + 3.
  - → data read returns 0x7B; the following status read returns 0x00.
- Send 0x3E then 0xFF back-to-back without reading → `data` stays 0x3E and status = 0xC0. A data read then returns 0x3E, and status returns 0x00.
- Frame 0x55 with stop bit driven 0 → status = 0xA0 and data = 0x55. Release the line high → no further frame is received.
- Glitch: `rx` low for 3 clocks only → FSM returns to IDLE and status stays 0x00. A subsequent valid 0x00 frame is received and data reads 0x00.
- Assert `rst` in the middle of data bit 4 of a frame, and release it with `rx` high → status 0x00. The next full 0xA5 frame is received correctly.
